// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF measurement controller: steps challenge select pairs,
// times clear/settle/measure/hold phases and assembles the comparison bits.
module puf_challenge_sequencer #(
   parameter int CNT_W  = 16,
   parameter int NBITS  = 8,
   parameter int WINDOW = 1024,
   parameter int SETTLE = 4,
   parameter int HOLD   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [9:0]       seed,
   input  logic [CNT_W-1:0] cnt_a,
   input  logic [CNT_W-1:0] cnt_b,
   output logic [4:0]       sel_a,
   output logic [4:0]       sel_b,
   output logic             osc_en,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] response,
   output logic             tie,
   output logic             sat
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_HOLD, S_COMPARE, S_DONE
   } state_t;

   localparam int MAX_A   = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int MAX_B   = (MAX_A > HOLD) ? MAX_A : HOLD;
   localparam int MAX_DUR = (MAX_B > 2) ? MAX_B : 2;
   localparam int TW      = $clog2(MAX_DUR);
   localparam int KW      = (NBITS > 1) ? $clog2(NBITS) : 1;

   state_t          state, state_next;
   logic [TW-1:0]   timer;
   logic [KW-1:0]   k;
   logic            timer_done, last_bit;
   logic            osc_en_d, cnt_clr_d, busy_d, done_d;

   assign timer_done = (timer == '0);
   assign last_bit   = (k == KW'(NBITS - 1));

   // Timer is loaded with (phase length - 1) on entry and counts down to zero.
   function automatic logic [TW-1:0] dur_m1(input state_t s);
      case (s)
         S_CLEAR:   return TW'(1);
         S_SETTLE:  return TW'(SETTLE - 1);
         S_MEASURE: return TW'(WINDOW - 1);
         S_HOLD:    return TW'(HOLD - 1);
         default:   return '0;
      endcase
   endfunction

   // NOTE: reset is asynchronous and asserted while rst_n is HIGH.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start)      state_next = S_CLEAR;
         S_CLEAR:   if (timer_done) state_next = S_SETTLE;
         S_SETTLE:  if (timer_done) state_next = S_MEASURE;
         S_MEASURE: if (timer_done) state_next = S_HOLD;
         S_HOLD:    if (timer_done) state_next = S_COMPARE;
         S_COMPARE: state_next = last_bit ? S_DONE : S_CLEAR;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered below, so each
   // output is a flop aligned exactly with the state it belongs to.
   always_comb begin
      osc_en_d  = (state_next == S_MEASURE);
      cnt_clr_d = (state_next == S_CLEAR);
      busy_d    = (state_next != S_IDLE);
      done_d    = (state_next == S_DONE);
   end

   // NOTE: all sequential state uses non-blocking assignments.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         osc_en   <= 1'b0;
         cnt_clr  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sel_a    <= '0;
         sel_b    <= '0;
         response <= '0;
         tie      <= 1'b0;
         sat      <= 1'b0;
         k        <= '0;
         timer    <= '0;
      end else begin
         osc_en  <= osc_en_d;
         cnt_clr <= cnt_clr_d;
         busy    <= busy_d;
         done    <= done_d;

         if (state_next != state) timer <= dur_m1(state_next);
         else if (!timer_done)    timer <= timer - TW'(1);

         case (state)
            S_IDLE: if (start) begin
               sel_a    <= seed[4:0];
               sel_b    <= seed[9:5];
               k        <= '0;
               response <= '0;
               tie      <= 1'b0;
               sat      <= 1'b0;
            end
            S_COMPARE: begin
               response[k] <= (cnt_a > cnt_b);
               if (cnt_a == cnt_b) tie <= 1'b1;
               if ((cnt_a == '1) || (cnt_b == '1)) sat <= 1'b1;
               // Selects advance only together with the move back into CLEAR.
               if (!last_bit) begin
                  k     <= k + KW'(1);
                  sel_a <= sel_a + 5'd1;
                  sel_b <= sel_b + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench for puf_challenge_sequencer: a cycle-schedule model derived
// from the per-bit period predicts every output on every cycle of a run.
module tb_puf_challenge_sequencer;

   localparam int CNT_W  = 16;
   localparam int NBITS  = 8;
   localparam int WINDOW = 16;
   localparam int SETTLE = 2;
   localparam int HOLD   = 2;
   localparam int P      = 2 + SETTLE + WINDOW + HOLD + 1;
   localparam int RUN    = NBITS * P;

   logic             clk = 1'b0;
   logic             rst_n, start;
   logic [9:0]       seed;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic [4:0]       sel_a, sel_b;
   logic             osc_en, cnt_clr, busy, done, tie, sat;
   logic [NBITS-1:0] response;
   logic [23:0]      obs;

   int checks   = 0;
   int failures = 0;

   logic [CNT_W-1:0] ca [NBITS];
   logic [CNT_W-1:0] cb [NBITS];

   puf_challenge_sequencer #(
      .CNT_W(CNT_W), .NBITS(NBITS), .WINDOW(WINDOW), .SETTLE(SETTLE), .HOLD(HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .sel_a(sel_a), .sel_b(sel_b),
      .osc_en(osc_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
      .response(response), .tie(tie), .sat(sat)
   );

   always #5 clk = ~clk;

   assign obs = {busy, done, osc_en, cnt_clr, sel_a, sel_b, response, tie, sat};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_random();
      for (int j = 0; j < NBITS; j++) begin
         ca[j] = CNT_W'($urandom);
         cb[j] = CNT_W'($urandom);
      end
   endtask

   // One run from a start at edge 0. Cycle c is the cycle after edge c.
   // abort_c >= 0 asserts reset during that cycle and ends the run there.
   task automatic run(input logic [9:0] s, input bit mid_starts, input int abort_c);
      int               k, off;
      bit               clr, osc, et, es;
      logic [4:0]       ea, eb;
      logic [NBITS-1:0] er;
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      seed  = 10'($urandom);
      for (int c = 0; c <= RUN + 2; c++) begin
         if (c == abort_c) begin
            rst_n = 1'b1;
            #1;
            check("abort_outputs", obs, '0);
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            return;
         end
         k   = (c < RUN) ? c / P : NBITS - 1;
         off = c % P;
         clr = (c < RUN) && (off < 2);
         osc = (c < RUN) && (off >= 2 + SETTLE) && (off < 2 + SETTLE + WINDOW);
         ea  = s[4:0] + 5'(k);
         eb  = s[9:5] + 5'(k);
         er  = '0;
         et  = 1'b0;
         es  = 1'b0;
         for (int j = 0; j < NBITS; j++) begin
            if ((j + 1) * P <= c) begin
               er[j] = ca[j] > cb[j];
               et    = et | (ca[j] == cb[j]);
               es    = es | (ca[j] == '1) | (cb[j] == '1);
            end
         end
         check($sformatf("cyc%0d", c), obs,
               {(c <= RUN), (c == RUN), osc, clr, ea, eb, er, et, es});
         if (c < RUN) begin
            cnt_a = ca[c / P];
            cnt_b = cb[c / P];
         end
         start = mid_starts && (c == 4 || c == 99);
         seed  = 10'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      seed  = '0;
      cnt_a = '0;
      cnt_b = '0;

      // Reset and idle
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      check("reset_outputs", obs, '0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 10 == 9) check("idle_busy", busy, 1'b0);
      end

      // Basic run
      for (int j = 0; j < NBITS; j++) begin
         ca[j] = CNT_W'(100 + j);
         cb[j] = (j % 2 == 0) ? CNT_W'(50) : CNT_W'(200);
      end
      run(10'h000, 1'b0, -1);
      check("basic_response", response, 8'h55);
      check("basic_flags", {tie, sat}, 2'b00);

      // Select wrap-around
      fill_random();
      run({5'd31, 5'd30}, 1'b0, -1);

      // Tie and saturation on k=3
      fill_random();
      for (int j = 0; j < NBITS; j++) begin
         if (ca[j] == cb[j]) cb[j] = ca[j] ^ CNT_W'(1);
         if (ca[j] == '1) ca[j] = CNT_W'(7);
         if (cb[j] == '1) cb[j] = CNT_W'(9);
      end
      ca[3] = 16'hFFFF;
      cb[3] = 16'hFFFF;
      run(10'($urandom), 1'b0, -1);
      repeat (5) @(negedge clk);
      check("tie_bit3", response[3], 1'b0);
      check("tie_flags", {tie, sat}, 2'b11);

      // start while busy
      fill_random();
      run(10'($urandom), 1'b1, -1);

      // Reset during MEASURE of k=4, then a fresh run
      fill_random();
      run(10'($urandom), 1'b0, 4 * P + 2 + SETTLE + 5);
      fill_random();
      run(10'($urandom), 1'b0, -1);

      // Further random runs
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run(10'($urandom), 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Measurement controller that sits directly in front of the ring-oscillator PUF banks and their edge counters. It generates a sequence of challenges (oscillator select pairs), clears the counters, and gates the oscillators for a fixed measurement window of system clocks. It then freezes the oscillators, samples and compares the two counts, and assembles the comparison bits into an NBITS-wide response word.

## Interface

Parameters:
- CNT_W, 16: width of each counter input.
- NBITS, 8: response bits per run, one challenge per bit.
- WINDOW, 1024: measurement window in clk cycles (≥1).
- SETTLE, 4: cycles with oscillators gated off after a select change (≥1).
- HOLD, 4: freeze cycles between oscillator disable and counter sampling (≥1).

Ports:
- clk, input, 1: system clock. Unrelated to the oscillator clocks.
- rst_n, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin a run. Sampled only in IDLE.
- seed, input, 10: challenge base. seed[4:0] is the bank-A base; seed[9:5] is the bank-B base.
- cnt_a, input, CNT_W: bank-A counter value. It is only required to be stable during COMPARE.
- cnt_b, input, CNT_W: bank-B counter value. Same stability rule as cnt_a.
- sel_a, output, 5: bank-A oscillator select.
- sel_b, output, 5: bank-B oscillator select.
- osc_en, output, 1: oscillator enable for both banks.
- cnt_clr, output, 1: counter clear, active-high.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the response is valid.
- response, output, NBITS: assembled response word.
- tie, output, 1: sticky flag. Set if any compared pair had cnt_a == cnt_b.
- sat, output, 1: sticky flag. Set if any sampled count was all-ones.

## Operation

- States: IDLE, CLEAR, SETTLE, MEASURE, HOLD, COMPARE, DONE.
- Index k counts 0..NBITS-1.
  - sel_a = seed_q[4:0] + k, modulo 32.
  - sel_b = seed_q[9:5] + k, modulo 32.
  - seed_q is seed captured on the accepted start.
  - sel_a and sel_b are registered and change only on entry to CLEAR.
- IDLE:
  - busy=0, osc_en=0, cnt_clr=0.
  - On start=1: capture seed, set k=0, clear response, tie and sat, then go to CLEAR.
- CLEAR: lasts 2 cycles with cnt_clr=1 and osc_en=0, then goes to SETTLE.
- SETTLE: lasts SETTLE cycles with osc_en=0 and cnt_clr=0, then goes to MEASURE.
- MEASURE: lasts WINDOW cycles with osc_en=1, then goes to HOLD.
- HOLD: lasts HOLD cycles with osc_en=0 so the counters settle, then goes to COMPARE.
- COMPARE (1 cycle):
  - Compare as unsigned full width; set response[k] = (cnt_a > cnt_b).
  - If cnt_a == cnt_b, the bit is 0 and tie is set.
  - If either count is all-ones, sat is set.
  - If k == NBITS-1, go to DONE; otherwise increment k and go to CLEAR.
- DONE: done=1 for one cycle, then go to IDLE.
- response, tie and sat hold their values until the next accepted start.
- start while busy is ignored; it is not queued.
- seed changes during a run have no effect.
- Reset:
  - At any time, including mid-run, reset forces IDLE immediately.
  - Reset values: sel_a=0, sel_b=0, osc_en=0, cnt_clr=0, busy=0, done=0, response=0, tie=0, sat=0, k=0.

## Timing

- Per-bit period P = 2 + SETTLE + WINDOW + HOLD + 1 cycles.
- If start is sampled at edge 0:
  - busy is high from edge 0.
  - done is high during the cycle after edge NBITS*P.
  - busy falls at edge NBITS*P+1.
- osc_en is high for exactly WINDOW consecutive cycles per bit, and never while cnt_clr=1 or while sel outputs change.
- cnt_a and cnt_b are sampled only at the COMPARE edge, at least HOLD cycles after osc_en falls. The bench must keep them stable from HOLD entry through COMPARE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Reset and idle:
  - Assert rst_n for 3 cycles, then release.
  - Required: all outputs are 0.
  - start held low for 100 cycles leaves busy=0.
- Basic run:
  - Parameters WINDOW=16, SETTLE=2, HOLD=2, NBITS=8 (P=23), seed=10'h000.
  - Counter model: cnt_a=100+k, cnt_b=50 for even k and 200 for odd k.
  - Required: response=8'h55; done pulses exactly once, 184 cycles after the start edge; tie=0 and sat=0.
- Select wrap-around:
  - seed={5'd31,5'd30}.
  - Required: (sel_a, sel_b) per bit are k=0 (30,31), k=1 (31,0), k=2 (0,1).
  - osc_en pulses are 16 cycles wide, and cnt_clr is 2 cycles before each.
- Tie and saturation:
  - cnt_a == cnt_b == 16'hFFFF on k=3 only.
  - Required: response[3]=0, tie=1, sat=1, and both flags persist after done.
- start while busy:
  - Pulse start at cycles 5 and 100 after the first start, with a different seed.
  - Required: single done at cycle 184; sel sequence follows the first seed only.
- Reset mid-run:
  - Assert rst_n during MEASURE of k=4.
  - Required: osc_en=0, busy=0 and response=0 immediately.
  - A fresh start then completes a normal run.
